// File: rtl/fifo_burst_reader.sv
// Purpose: drain stage after the synchronous FIFO. It pops words from the FIFO and sends them out as bursts of BURST_LEN beats.
// Latency: a word reaches m_data two cycles after its fifo_rd_en. A lone word at the tail waits until its successor arrives, or until a timeout.
// Backpressure: a 3-entry skid buffer absorbs m_ready stalls. Reads are throttled so the buffer never overflows.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   fifo_empty      FIFO empty flag
//   fifo_rd_en      FIFO pop request (combinational)
//   fifo_rd_data    FIFO read data, valid the cycle after fifo_rd_en
//   m_valid/m_ready output stream handshake
//   m_data          output beat data (buffer head register)
//   m_last          final beat of the current burst
module fifo_burst_reader #(
  parameter int DATAWIDTH = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [DATAWIDTH-1:0] fifo_rd_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATAWIDTH-1:0] m_data,
  output logic                 m_last
);

  localparam int BEAT_W = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

  logic [DATAWIDTH-1:0] buf_q [3];
  logic [DATAWIDTH-1:0] buf_d [3];
  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic                 flush_q, flush_d;

  logic                 pop;
  logic                 hold;
  logic [2:0]           level;   // occupancy after this cycle's pop and capture
  logic [1:0]           tail;    // slot that receives the word landing this cycle

  // Output side and read issue
  always_comb begin
    // A lone head word is only released when its last-ness is already known.
    // That holds when it closes a full burst, or when a flush forces it out.
    m_valid    = (occ_q != 2'd0) &&
                 ((occ_q >= 2'd2) || inflight_q || (beat_cnt_q == LAST_BEAT) || flush_q);
    m_last     = (beat_cnt_q == LAST_BEAT) || flush_q;
    m_data     = buf_q[0];
    pop        = m_valid && m_ready;
    level      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    // Gated by rst_n so that no pop leaks out while reset is held.
    fifo_rd_en = rst_n && !fifo_empty && (level < 3'd3);
    hold       = (occ_q == 2'd1) && !inflight_q && fifo_empty && !m_valid;
    tail       = occ_q - {1'b0, pop};
    occ_d      = level[1:0];
  end

  // Skid buffer: shift on pop, then drop the arriving word into the new tail
  always_comb begin
    buf_d = buf_q;
    if (pop) begin
      buf_d[0] = buf_q[1];
      buf_d[1] = buf_q[2];
    end
    if (inflight_q) begin
      case (tail)
        2'd0:    buf_d[0] = fifo_rd_data;
        2'd1:    buf_d[1] = fifo_rd_data;
        default: buf_d[2] = fifo_rd_data;
      endcase
    end
  end

  // Burst position, idle timer and flush
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    flush_d    = flush_q;
    idle_cnt_d = '0;
    if (pop) begin
      if (m_last) begin
        beat_cnt_d = '0;
        flush_d    = 1'b0;
      end else begin
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      end
    end
    // hold implies !m_valid, so a pop and a flush can never be set together.
    // If hold drops in the cycle the timer is full, the timer just clears and no flush is raised.
    if (hold) begin
      if (idle_cnt_q == IDLE_MAX) begin
        flush_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
      flush_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) buf_q[i] <= buf_d[i];
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      flush_q    <= flush_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  fifo_burst_reader #(.DATAWIDTH(8), .BURST_LEN(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         nb = 0;
  int         base = 0;
  int         rd_viol = 0;
  int         stab_viol = 0;
  logic [7:0] q[$];
  logic [7:0] beat_dat [64];
  logic       beat_last[64];
  int         beat_cyc [64];
  logic       hold_pend = 1'b0;
  logic [7:0] hold_dat;
  logic       hold_last;
  logic       rd_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle. Outputs are observed at the falling edge. The FIFO model and other inputs update 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (fifo_rd_en && fifo_empty) rd_viol++;
    if (hold_pend && !(m_valid && m_data == hold_dat && m_last == hold_last)) stab_viol++;
    hold_pend = m_valid && !m_ready;
    hold_dat  = m_data;
    hold_last = m_last;
    if (m_valid && m_ready && nb < 64) begin
      beat_dat[nb]  = m_data;
      beat_last[nb] = m_last;
      beat_cyc[nb]  = cyc;
      nb++;
    end
    rd_s = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd_s && q.size() > 0) fifo_rd_data = q.pop_front();
    fifo_empty = (q.size() == 0);
  endtask

  task automatic chk_burst(input string tag, input int b, input int n,
                           input logic [7:0] first, input logic [7:0] lastv);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_dat"},  32'(beat_dat[b+i]),  32'(first + 8'(i)));
      chk({tag, "_last"}, 32'(beat_last[b+i]), 32'(lastv[i]));
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_data = 8'h00;
    m_ready      = 1'b1;

    // Reset state. The FIFO is already non-empty, so fifo_rd_en must stay low.
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en",   32'(fifo_rd_en), 32'd0);
    chk("rst_m_valid", 32'(m_valid),    32'd0);
    chk("rst_m_last",  32'(m_last),     32'd0);
    chk("rst_m_data",  32'(m_data),     32'd0);
    rst_n = 1'b1;

    // Full throughput: 8 back-to-back beats. m_last is set on 0x13 and 0x17.
    base = nb;
    repeat (20) tick();
    chk("thr_count", 32'(nb - base), 32'd8);
    chk_burst("thr", base, 8, 8'h10, 8'h88);
    chk("thr_consec", 32'(beat_cyc[base+7] - beat_cyc[base]), 32'd7);

    // Partial burst closed by timeout.
    // H starts in the cycle after the 0xA0 beat. 0xA1 is emitted 17 cycles later.
    base = nb;
    push(8'hA0);
    push(8'hA1);
    repeat (30) tick();
    chk("to_count", 32'(nb - base), 32'd2);
    chk_burst("to", base, 2, 8'hA0, 8'h02);
    chk("to_delay", 32'(beat_cyc[base+1] - beat_cyc[base] - 1), 32'd17);
    // The next word starts a fresh burst, so the 4th word carries m_last.
    base = nb;
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    repeat (10) tick();
    chk("to_next_count", 32'(nb - base), 32'd4);
    chk_burst("to_next", base, 4, 8'hC0, 8'h08);

    // Backpressure: m_ready is held low for 5 cycles while 0x22 is at the head.
    base = nb;
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      if (nb >= base + 2) break;
      tick();
    end
    chk("bp_reach_beat2", 32'(nb - base), 32'd2);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_stall_valid", 32'(m_valid), 32'd1);
      chk("bp_stall_data",  32'(m_data),  32'h22);
      chk("bp_stall_last",  32'(m_last),  32'd0);
      tick();
    end
    m_ready = 1'b1;
    repeat (15) tick();
    chk("bp_count", 32'(nb - base), 32'd8);
    chk_burst("bp", base, 8, 8'h20, 8'h88);

    // A word arrives while a flushed beat is stalled.
    m_ready = 1'b0;
    base = nb;
    push(8'hB0);
    for (int i = 0; i < 40; i++) begin
      if (m_valid) break;
      tick();
    end
    chk("fl_valid", 32'(m_valid), 32'd1);
    chk("fl_data",  32'(m_data),  32'hB0);
    chk("fl_last",  32'(m_last),  32'd1);
    for (int i = 0; i < 4; i++) push(8'hB5 + 8'(i));
    repeat (6) tick();
    chk("fl_hold_valid", 32'(m_valid), 32'd1);
    chk("fl_hold_data",  32'(m_data),  32'hB0);
    chk("fl_hold_last",  32'(m_last),  32'd1);
    m_ready = 1'b1;
    repeat (12) tick();
    chk("fl_count", 32'(nb - base), 32'd5);
    chk_burst("fl_head", base, 1, 8'hB0, 8'h01);
    chk_burst("fl_next", base + 1, 4, 8'hB5, 8'h08);

    // Reset mid-burst at beat 2, with two words buffered and one read in flight.
    base = nb;
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      if (nb >= base + 2) break;
      tick();
    end
    m_ready = 1'b0;
    tick();
    #2;
    rst_n     = 1'b0;
    hold_pend = 1'b0;
    #1;
    chk("mrst_rd_en",   32'(fifo_rd_en), 32'd0);
    chk("mrst_m_valid", 32'(m_valid),    32'd0);
    chk("mrst_m_last",  32'(m_last),     32'd0);
    chk("mrst_m_data",  32'(m_data),     32'd0);
    q.delete();
    fifo_empty = 1'b1;
    repeat (2) tick();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    repeat (10) tick();
    chk("mrst_count", 32'(nb - base), 32'd6);
    chk_burst("mrst_pre", base, 2, 8'h30, 8'h00);
    chk_burst("mrst_post", base + 2, 4, 8'h40, 8'h08);

    chk("rd_en_while_empty", 32'(rd_viol),   32'd0);
    chk("stall_stability",   32'(stab_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Downstream drain stage for the team's synchronous FIFO.
- Pops words through the FIFO's read port, which has one-cycle read latency.
- Re-emits them on a valid/ready stream grouped into bursts of BURST_LEN beats, with `m_last` on the final beat.
- Holds back the most recent word until it knows whether that word is the last of a burst.
- A partial burst is closed by a timeout when the FIFO stays empty.

## Interface
- `DATAWIDTH`, default 8: word width; must match the FIFO.
- `BURST_LEN`, default 4: beats per full burst; must be ≥ 2.
- `TIMEOUT`, default 16: idle cycles before a partial burst is closed; must be ≥ 1.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rd_en`  out  1: FIFO pop request, combinational.
- `fifo_rd_data`  in  DATAWIDTH: FIFO read data, valid in the cycle after `fifo_rd_en`.
- `m_valid`  out  1: output beat valid.
- `m_ready`  in  1: downstream accept.
- `m_data`  out  DATAWIDTH: output beat data, driven from the buffer head register.
- `m_last`  out  1: final beat of the burst.

## Operation
- **Internal state**
  - 3-entry skid buffer (`occ` 0..3).
  - `inflight` flag: a read was issued last cycle.
  - `beat_cnt` 0..BURST_LEN-1.
  - `idle_cnt` 0..TIMEOUT.
  - `flush` flag.
- **Read issue:** `fifo_rd_en` = `!fifo_empty && (occ + inflight - pop) < 3`, where `pop = m_valid && m_ready`.
  - Never asserted while `fifo_empty` is high.
  - Never asserted during reset.
- **Data capture:** when `inflight` is 1, `fifo_rd_data` is written into the buffer tail on that edge.
  - `occ` is updated as `occ + inflight - pop`.
  - The buffer must never overflow.
- **Head eligibility:** `m_valid` = `occ ≥ 1 && (occ ≥ 2 || inflight || beat_cnt == BURST_LEN-1 || flush)`.
  - A lone head word waits while its successor is unknown.
- **`m_last`:** `(beat_cnt == BURST_LEN-1) || flush`.
- **On pop:**
  - Shift the buffer.
  - If `m_last`: `beat_cnt` ← 0 and `flush` ← 0.
  - Otherwise: `beat_cnt` ← `beat_cnt` + 1.
- **Hold condition H:** `occ == 1 && !inflight && fifo_empty && !m_valid`.
  - `idle_cnt` increments while H holds and clears to 0 whenever H is false.
  - When `idle_cnt` reaches TIMEOUT, `flush` ← 1 and `idle_cnt` clears.
- **Flush latching:** once `m_valid` has risen with `flush` = 1, `flush` stays 1 until that beat is accepted.
  - A word arriving meanwhile does not clear it.
  - That word starts the next burst at beat 0.
- **AXI-style stability:** while `m_valid && !m_ready`, `m_data` and `m_last` hold stable and `m_valid` does not fall.
- **`beat_cnt` wrap:** wraps only via `m_last`; there is no other wrap path.

## Timing
- **Reset:** asynchronous assertion clears everything.
  - `occ`, `inflight`, `beat_cnt`, `idle_cnt`, `flush` ← 0.
  - `m_valid` = 0, `m_last` = 0, `m_data` = 0, `fifo_rd_en` = 0.
  - A read in flight at reset is discarded.
- **Read latency:** `fifo_rd_en` high in cycle n → data captured at the end of cycle n+1 → visible on `m_data` from cycle n+2, subject to eligibility.
- **Throughput:** with `m_ready` high and the FIFO non-empty, the block sustains one beat per cycle after the first two-word fill.
- **Timeout:** `m_valid` for a lone held word rises TIMEOUT+1 cycles after H first becomes true.
- **Simultaneous pop and capture:** the buffer must hold the correct order and count.
- **Simultaneous H-break and timeout:** if H breaks in the same cycle `idle_cnt` would reach TIMEOUT, no flush occurs.

## Test plan
- **Full throughput:** FIFO preloaded with 8 words 0x10..0x17, `m_ready` = 1.
  - Required: 8 consecutive beats in order.
  - `m_last` high on 0x13 and 0x17 only.
  - `fifo_rd_en` never high with `fifo_empty`.
- **Partial burst by timeout:** 2 words 0xA0, 0xA1, then the FIFO stays empty, TIMEOUT = 16.
  - Required: 0xA0 beat with `m_last` = 0.
  - 0xA1 appears 17 cycles after H starts, with `m_last` = 1.
  - Next word starts at beat 0.
- **Backpressure:** 8 words, `m_ready` low for 5 cycles at beat 2.
  - Required: `m_valid` stays high and `m_data`/`m_last` stay stable.
  - `occ` never exceeds 3.
  - No word is lost or duplicated.
- **Word arrives during flush:** a lone word times out, `m_ready` = 0, then a new word 0xB5 is written.
  - Required: the held beat keeps `m_last` = 1.
  - 0xB5 is emitted after it with `m_last` = 0, at beat 0.
- **Reset mid-burst:** `rst_n` pulsed low at beat 2 with `occ` = 2 and a read in flight.
  - Required: all outputs are 0 immediately.
  - After release, the first word read is beat 0 with no stale data.
